reg_list_writer: RTL and testbench

REG_LIST_WRITER -- requirements
Module: reg_list_writer

---
 rtl/reg_list_writer_if.sv | 39 +++
 rtl/reg_list_writer.sv | 101 ++++++++++
 tb/tb_reg_list_writer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/reg_list_writer_if.sv
// ---------------------------------------------------------------------------
// reg_list_writer_if
// Bundles the request, memory-beat and register-file-write signals of
// reg_list_writer.
//   master : requester / memory side (drives start, regList, memData, memValid)
//   slave  : reg_list_writer itself (drives memReady and all write/status outputs)
// Signals:
//   start, regList      : block-load request and the register mask
//   memData, memValid   : incoming load beat
//   memReady            : block accepts a beat this cycle
//   regWrite, writeRegister, writeData : register-file write port
//   busy, done, count   : transfer status
// ---------------------------------------------------------------------------
interface reg_list_writer_if #(
   parameter int WORD_LEN  = 32,
   parameter int REG_COUNT = 16
);
   logic                 start;
   logic [REG_COUNT-1:0] regList;
   logic [WORD_LEN-1:0]  memData;
   logic                 memValid;
   logic                 memReady;
   logic                 regWrite;
   logic [3:0]           writeRegister;
   logic [WORD_LEN-1:0]  writeData;
   logic                 busy;
   logic                 done;
   logic [4:0]           count;

   modport master (
      output start, regList, memData, memValid,
      input  memReady, regWrite, writeRegister, writeData, busy, done, count
   );

   modport slave (
      input  start, regList, memData, memValid,
      output memReady, regWrite, writeRegister, writeData, busy, done, count
   );
endinterface

// File: rtl/reg_list_writer.sv
// ---------------------------------------------------------------------------
// reg_list_writer
// Block register load: a start request latches a register mask, then each
// accepted memory beat is written to the lowest still-pending register, in
// ascending index order. done pulses with the final write (or on the cycle
// after a start with an empty mask).
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset; aborts any transfer in progress
//   bus_if : reg_list_writer_if.slave (request, beats, write port, status)
// ---------------------------------------------------------------------------
module reg_list_writer #(
   parameter int WORD_LEN  = 32,
   parameter int REG_COUNT = 16
) (
   input  logic            clk,
   input  logic            rst,
   reg_list_writer_if.slave bus_if
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t               state_q;
   logic [REG_COUNT-1:0] pending_q;
   logic [4:0]           count_q;
   logic                 reg_write_q;
   logic [3:0]           write_register_q;
   logic [WORD_LEN-1:0]  write_data_q;
   logic                 done_q;

   logic [3:0]           low_idx_d;
   logic [REG_COUNT-1:0] pending_d;
   logic                 beat_accept;

   // Lowest set bit of the pending mask; scanning downward lets the lowest win.
   always_comb begin
      low_idx_d = '0;
      for (int i = REG_COUNT - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            low_idx_d = 4'(i);
         end
      end
   end

   // Clearing the lowest set bit: x & (x - 1).
   assign pending_d   = pending_q & (pending_q - REG_COUNT'(1));
   assign beat_accept = (state_q == BUSY) && bus_if.memValid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         pending_q        <= '0;
         count_q          <= '0;
         reg_write_q      <= 1'b0;
         write_register_q <= '0;
         write_data_q     <= '0;
         done_q           <= 1'b0;
      end else begin
         // Pulses default low; writeRegister/writeData hold their last values.
         reg_write_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus_if.start) begin
                  count_q <= '0;
                  if (bus_if.regList != '0) begin
                     pending_q <= bus_if.regList;
                     state_q   <= BUSY;
                  end else begin
                     // Empty list: nothing to write, complete immediately.
                     done_q <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (beat_accept) begin
                  reg_write_q      <= 1'b1;
                  write_register_q <= low_idx_d;
                  write_data_q     <= bus_if.memData;
                  pending_q        <= pending_d;
                  count_q          <= count_q + 5'd1;
                  if (pending_d == '0) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_if.memReady      = (state_q == BUSY);
   assign bus_if.busy          = (state_q == BUSY);
   assign bus_if.regWrite      = reg_write_q;
   assign bus_if.writeRegister = write_register_q;
   assign bus_if.writeData     = write_data_q;
   assign bus_if.done          = done_q;
   assign bus_if.count         = count_q;

endmodule

// File: tb/tb_reg_list_writer.sv
// ---------------------------------------------------------------------------
// tb_reg_list_writer
// Directed bench for reg_list_writer. Inputs change 1 time unit after the
// rising edge and outputs are checked at the same point, so every check sees
// the state produced by the edge just taken.
// ---------------------------------------------------------------------------
module tb_reg_list_writer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   reg_list_writer_if #(.WORD_LEN(32), .REG_COUNT(16)) bus ();

   reg_list_writer #(.WORD_LEN(32), .REG_COUNT(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks the write port and status outputs in one call.
   task automatic check_cycle(input string tag, input logic rw, input logic [3:0] wr,
                              input logic [31:0] wd, input logic bz, input logic dn,
                              input logic [4:0] cnt);
      check({tag, ".regWrite"}, 32'(bus.regWrite), 32'(rw));
      if (rw) begin
         check({tag, ".writeRegister"}, 32'(bus.writeRegister), 32'(wr));
         check({tag, ".writeData"}, bus.writeData, wd);
      end
      check({tag, ".busy"}, 32'(bus.busy), 32'(bz));
      check({tag, ".memReady"}, 32'(bus.memReady), 32'(bz));
      check({tag, ".done"}, 32'(bus.done), 32'(dn));
      check({tag, ".count"}, 32'(bus.count), 32'(cnt));
      $display("[%0t] %s regWrite=%0b reg=%0d data=%h busy=%0b done=%0b count=%0d",
               $time, tag, bus.regWrite, bus.writeRegister, bus.writeData,
               bus.busy, bus.done, bus.count);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.regList  = '0;
      bus.memData  = '0;
      bus.memValid = 1'b0;

      // ---- reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst.writeRegister", 32'(bus.writeRegister), 32'd0);
      check("rst.writeData", bus.writeData, 32'd0);
      check_cycle("rst", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd0);

      // ---- list 0x0011, memValid held high: reg0<-A, reg4<-B
      bus.start = 1'b1; bus.regList = 16'h0011;
      bus.memValid = 1'b1; bus.memData = 32'hAAAA_0001;
      tick();
      bus.start = 1'b0;
      check_cycle("t1.enter", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 5'd0);
      tick();
      bus.memData = 32'hBBBB_0002;
      check_cycle("t1.w0", 1'b1, 4'd0, 32'hAAAA_0001, 1'b1, 1'b0, 5'd1);
      tick();
      bus.memValid = 1'b0;
      check_cycle("t1.w1", 1'b1, 4'd4, 32'hBBBB_0002, 1'b0, 1'b1, 5'd2);
      tick();
      check_cycle("t1.after", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd2);
      check("t1.hold.writeRegister", 32'(bus.writeRegister), 32'd4);
      check("t1.hold.writeData", bus.writeData, 32'hBBBB_0002);

      // ---- list 0x8002 with a 3-cycle memValid gap
      bus.start = 1'b1; bus.regList = 16'h8002;
      tick();
      bus.start = 1'b0;
      bus.memValid = 1'b1; bus.memData = 32'hCCCC_0003;
      check_cycle("t2.enter", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 5'd0);
      tick();
      bus.memValid = 1'b0;
      check_cycle("t2.w0", 1'b1, 4'd1, 32'hCCCC_0003, 1'b1, 1'b0, 5'd1);
      for (int g = 0; g < 3; g++) begin
         tick();
         check_cycle("t2.gap", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 5'd1);
      end
      bus.memValid = 1'b1; bus.memData = 32'hDDDD_0004;
      tick();
      bus.memValid = 1'b0;
      check_cycle("t2.w1", 1'b1, 4'd15, 32'hDDDD_0004, 1'b0, 1'b1, 5'd2);
      tick();
      check_cycle("t2.after", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd2);

      // ---- empty list from a freshly reset block
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.start = 1'b1; bus.regList = 16'h0000;
      tick();
      bus.start = 1'b0;
      check_cycle("t3.done", 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd0);
      tick();
      check_cycle("t3.after", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd0);

      // ---- start held with a different list while BUSY is ignored
      bus.start = 1'b1; bus.regList = 16'h0006;
      tick();
      bus.regList = 16'h0101;
      bus.memValid = 1'b1; bus.memData = 32'hEEEE_0005;
      check_cycle("t4.enter", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 5'd0);
      tick();
      bus.memData = 32'hFFFF_0006;
      check_cycle("t4.w0", 1'b1, 4'd1, 32'hEEEE_0005, 1'b1, 1'b0, 5'd1);
      tick();
      bus.start = 1'b0; bus.memValid = 1'b0;
      check_cycle("t4.w1", 1'b1, 4'd2, 32'hFFFF_0006, 1'b0, 1'b1, 5'd2);
      tick();
      check_cycle("t4.after", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd2);

      // ---- reset after 2 of 5 writes (beat and start present with rst)
      bus.start = 1'b1; bus.regList = 16'h001F;
      bus.memValid = 1'b1; bus.memData = 32'h5000_0000;
      tick();
      bus.start = 1'b0;
      bus.memData = 32'h5000_0001;
      tick();
      check_cycle("t5.w0", 1'b1, 4'd0, 32'h5000_0001, 1'b1, 1'b0, 5'd1);
      bus.memData = 32'h5000_0002;
      tick();
      check_cycle("t5.w1", 1'b1, 4'd1, 32'h5000_0002, 1'b1, 1'b0, 5'd2);
      rst = 1'b1; bus.start = 1'b1; bus.memData = 32'h5000_0003;
      tick();
      rst = 1'b0; bus.start = 1'b0;
      check_cycle("t5.rst", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd0);
      check("t5.rst.writeRegister", 32'(bus.writeRegister), 32'd0);
      check("t5.rst.writeData", bus.writeData, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_cycle("t5.post", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd0);
      end
      bus.memValid = 1'b0;

      // ---- full list 0xFFFF, 16 back-to-back beats, restart in done cycle
      bus.start = 1'b1; bus.regList = 16'hFFFF;
      bus.memValid = 1'b1; bus.memData = 32'h1000_0000;
      tick();
      bus.start = 1'b0;
      check_cycle("t6.enter", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 5'd0);
      for (int i = 0; i < 16; i++) begin
         tick();
         bus.memData = 32'h1000_0000 + 32'(i + 1);
         check_cycle($sformatf("t6.w%0d", i), 1'b1, 4'(i), 32'h1000_0000 + 32'(i),
                     (i != 15), (i == 15), 5'(i + 1));
      end
      // Done cycle: present a new request now.
      bus.start = 1'b1; bus.regList = 16'h0003; bus.memValid = 1'b0;
      tick();
      bus.start = 1'b0;
      check_cycle("t6.restart", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 5'd0);
      bus.memValid = 1'b1; bus.memData = 32'h2000_0000;
      tick();
      bus.memData = 32'h2000_0001;
      check_cycle("t6.r0", 1'b1, 4'd0, 32'h2000_0000, 1'b1, 1'b0, 5'd1);
      tick();
      bus.memValid = 1'b0;
      check_cycle("t6.r1", 1'b1, 4'd1, 32'h2000_0001, 1'b0, 1'b1, 5'd2);
      tick();
      check_cycle("t6.end", 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
